// File: rtl/fft_pkg.sv
// Shared definitions for the radix-2 DIT FFT butterfly scheduler.
// Holds the transform size, the derived address/index widths, the FSM state
// type, and the (stage, butterfly) -> {addr_a, addr_b, tw_idx} mapping used by
// the scheduler datapath.
package fft_pkg;

   localparam int LOG2N  = 4;
   localparam int ADDR_W = LOG2N;
   localparam int TW_W   = LOG2N - 1;
   localparam int STG_W  = $clog2(LOG2N);
   localparam int K_W    = LOG2N - 1;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DRAIN,
      DONE
   } fsm_state_e;

   typedef struct packed {
      logic [ADDR_W-1:0] addr_a;
      logic [ADDR_W-1:0] addr_b;
      logic [TW_W-1:0]   tw_idx;
   } bfly_addr_t;

   function automatic bfly_addr_t bfly_addr(input logic [STG_W-1:0] s,
                                            input logic [K_W-1:0]   k);
      logic [ADDR_W-1:0] kx;
      logic [ADDR_W-1:0] half;
      logic [ADDR_W-1:0] pos;
      logic [ADDR_W-1:0] grp;
      bfly_addr_t        r;
      kx       = ADDR_W'(k);
      half     = ADDR_W'(1) << s;
      pos      = kx & (half - ADDR_W'(1));
      grp      = kx >> s;
      r.addr_a = (grp << (int'(s) + 1)) | pos;
      // bit s of addr_a is always clear, so adding half never carries out
      r.addr_b = r.addr_a + half;
      r.tw_idx = TW_W'(pos << (TW_W - int'(s)));
      return r;
   endfunction

endpackage

// File: rtl/fft_sched_dly.sv
// Enable-gated shift register with asynchronous clear, used to delay the read
// issue {vld, addr_a, addr_b} by the butterfly pipeline latency.
//   clk  : system clock
//   rstn : async active-low clear of every stage
//   en   : shift enable (low freezes the whole line)
//   d    : value entering the line
//   q    : value leaving the line, DEPTH enabled shifts after entry
module fft_sched_dly #(
   parameter int DEPTH = 2,
   parameter int W     = 1
) (
   input  logic         clk,
   input  logic         rstn,
   input  logic         en,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   logic [W-1:0] sr [DEPTH];

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int i = 0; i < DEPTH; i++) sr[i] <= '0;
      end else if (en) begin
         sr[0] <= d;
         for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
      end
   end

   assign q = sr[DEPTH-1];

endmodule

// File: rtl/fft_bfly_sched.sv
// Address/control scheduler for an in-place radix-2 DIT FFT.
// Issues N/2 butterflies per stage (one per cycle), then drains the butterfly
// pipeline before the next stage so every write lands before it is re-read.
//   clk, rstn          : clock, async active-low reset
//   start              : run request, honoured only in IDLE
//   hold               : stall while RUN/DRAIN; freezes FSM, counters, delay line
//   busy, done         : transform in progress / one-cycle completion pulse
//   stage              : current stage index
//   rd_vld, rd_addr_*  : operand read issue
//   tw_idx             : twiddle ROM index for the issued butterfly
//   wr_vld, wr_addr_*  : write-back, PIPE_LAT unstalled cycles after the read
//
// state | meaning
// IDLE  | waiting for start
// RUN   | issuing butterfly k of the current stage each unstalled cycle
// DRAIN | PIPE_LAT unstalled bubble cycles so the stage's last write lands
// DONE  | single cycle; produces the done pulse, stage returns to 0
module fft_bfly_sched
   import fft_pkg::*;
#(
   parameter int PIPE_LAT = 2
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              start,
   input  logic              hold,
   output logic              busy,
   output logic              done,
   output logic [STG_W-1:0]  stage,
   output logic              rd_vld,
   output logic [ADDR_W-1:0] rd_addr_a,
   output logic [ADDR_W-1:0] rd_addr_b,
   output logic [TW_W-1:0]   tw_idx,
   output logic              wr_vld,
   output logic [ADDR_W-1:0] wr_addr_a,
   output logic [ADDR_W-1:0] wr_addr_b
);

   localparam int               DRN_W    = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
   localparam int               DLY_W    = 1 + 2 * ADDR_W;
   localparam logic [K_W-1:0]   K_LAST   = '1;
   localparam logic [STG_W-1:0] STG_LAST = STG_W'(LOG2N - 1);
   localparam logic [DRN_W-1:0] DRN_LAST = DRN_W'(PIPE_LAT - 1);

   fsm_state_e       state_q, state_d;
   logic [K_W-1:0]   k_q, k_d;
   logic [STG_W-1:0] stg_q, stg_d;
   logic [DRN_W-1:0] drn_q, drn_d;
   logic             active;
   logic             adv;
   logic             held_q;
   logic             rd_vld_q;
   bfly_addr_t       addr;
   logic [DLY_W-1:0] dly_q;

   assign active = (state_q == RUN) || (state_q == DRAIN);
   assign adv    = !(hold && active);
   assign addr   = bfly_addr(stg_q, k_q);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= IDLE;
         k_q     <= '0;
         stg_q   <= '0;
         drn_q   <= '0;
      end else begin
         state_q <= state_d;
         k_q     <= k_d;
         stg_q   <= stg_d;
         drn_q   <= drn_d;
      end
   end

   always_comb begin
      state_d = state_q;
      k_d     = k_q;
      stg_d   = stg_q;
      drn_d   = drn_q;
      case (state_q)
         IDLE: begin
            // done is the registered image of DONE; a start landing while it
            // is still visible belongs to the finished transform and is dropped
            if (start && !done) begin
               state_d = RUN;
               k_d     = '0;
               stg_d   = '0;
            end
         end
         RUN: begin
            if (!hold) begin
               k_d = k_q + K_W'(1);
               if (k_q == K_LAST) begin
                  k_d     = '0;
                  drn_d   = '0;
                  state_d = DRAIN;
               end
            end
         end
         DRAIN: begin
            if (!hold) begin
               drn_d = drn_q + DRN_W'(1);
               if (drn_q == DRN_LAST) begin
                  drn_d = '0;
                  if (stg_q == STG_LAST) begin
                     state_d = DONE;
                  end else begin
                     stg_d   = stg_q + STG_W'(1);
                     state_d = RUN;
                  end
               end
            end
         end
         DONE: begin
            stg_d   = '0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Read issue register. On a stalled edge it keeps its contents (so the
   // pending issue still enters the delay line exactly once later) and the
   // visible valids are masked for the following cycle via held_q.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         busy      <= 1'b0;
         done      <= 1'b0;
         held_q    <= 1'b0;
         rd_vld_q  <= 1'b0;
         rd_addr_a <= '0;
         rd_addr_b <= '0;
         tw_idx    <= '0;
      end else begin
         busy   <= active;
         done   <= (state_q == DONE);
         held_q <= !adv;
         if (adv) begin
            rd_vld_q <= (state_q == RUN);
            if (state_q == RUN) begin
               rd_addr_a <= addr.addr_a;
               rd_addr_b <= addr.addr_b;
               tw_idx    <= addr.tw_idx;
            end
         end
      end
   end

   fft_sched_dly #(
      .DEPTH(PIPE_LAT),
      .W    (DLY_W)
   ) u_dly (
      .clk (clk),
      .rstn(rstn),
      .en  (adv),
      .d   ({rd_vld_q, rd_addr_a, rd_addr_b}),
      .q   (dly_q)
   );

   assign stage     = stg_q;
   assign rd_vld    = rd_vld_q & ~held_q;
   assign wr_vld    = dly_q[DLY_W-1] & ~held_q;
   assign wr_addr_a = dly_q[2*ADDR_W-1 -: ADDR_W];
   assign wr_addr_b = dly_q[ADDR_W-1:0];

endmodule

// File: tb/tb_fft_bfly_sched.sv
// Self-checking bench for fft_bfly_sched (LOG2N=4, PIPE_LAT=2).
`timescale 1ns/1ps
module tb_fft_bfly_sched;
   import fft_pkg::*;

   localparam int PIPE_LAT = 2;
   localparam int NBF      = 32;

   logic              clk, rstn, start, hold;
   logic              busy, done, rd_vld, wr_vld;
   logic [STG_W-1:0]  stage;
   logic [ADDR_W-1:0] rd_addr_a, rd_addr_b, wr_addr_a, wr_addr_b;
   logic [TW_W-1:0]   tw_idx;

   fft_bfly_sched #(.PIPE_LAT(PIPE_LAT)) dut (
      .clk      (clk),
      .rstn     (rstn),
      .start    (start),
      .hold     (hold),
      .busy     (busy),
      .done     (done),
      .stage    (stage),
      .rd_vld   (rd_vld),
      .rd_addr_a(rd_addr_a),
      .rd_addr_b(rd_addr_b),
      .tw_idx   (tw_idx),
      .wr_vld   (wr_vld),
      .wr_addr_a(wr_addr_a),
      .wr_addr_b(wr_addr_b)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      int s;
      int k;
      int a;
      int b;
      int tw;
   } vec_t;

   typedef struct {
      int a;
      int b;
      int nh;
   } sb_t;

   vec_t tbl[5];
   vec_t exp_rd_q[$];
   sb_t  sb_q[$];
   int   obs_a[4][8];
   int   obs_b[4][8];
   int   obs_tw[4][8];
   int   checks   = 0;
   int   failures = 0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic int all_outs();
      return int'({busy, done, stage, rd_vld, rd_addr_a, rd_addr_b, tw_idx,
                   wr_vld, wr_addr_a, wr_addr_b});
   endfunction

   task automatic load_expected();
      bfly_addr_t r;
      vec_t       v;
      exp_rd_q.delete();
      sb_q.delete();
      for (int s = 0; s < LOG2N; s++) begin
         for (int k = 0; k < 8; k++) begin
            r    = bfly_addr(STG_W'(s), K_W'(k));
            v.s  = s;
            v.k  = k;
            v.a  = int'(r.addr_a);
            v.b  = int'(r.addr_b);
            v.tw = int'(r.tw_idx);
            exp_rd_q.push_back(v);
         end
      end
   endtask

   // start is high through the edge that becomes cycle 0 of the run
   task automatic kick();
      load_expected();
      @(posedge clk); #1;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   // Steps cycles 1..done_exp (or 1..abort_cyc) of a transform, driving hold
   // windows and stray starts, and checking every sampled cycle.
   task automatic run(input int h1_lo, input int h1_hi, input int h2_lo, input int h2_hi,
                      input int mid_start, input int done_exp, input bit timing,
                      input bit record, input bit late_start, input int abort_cyc);
      int   last_c, nh, last_rd_nh, rd_cnt, wr_cnt, bcnt;
      int   pa, pb, ptw, pwa, pwb, pst;
      bit   prev_hold, gated;
      vec_t e;
      sb_t  w;
      last_c     = (abort_cyc > 0) ? abort_cyc : done_exp;
      nh         = 0;
      last_rd_nh = -100;
      rd_cnt     = 0;
      wr_cnt     = 0;
      bcnt       = 0;
      prev_hold  = 1'b0;
      pa = 0; pb = 0; ptw = 0; pwa = 0; pwb = 0; pst = 0;
      for (int c = 1; c <= last_c; c++) begin
         @(posedge clk); #1;
         hold  = ((c >= h1_lo) && (c <= h1_hi)) || ((c >= h2_lo) && (c <= h2_hi));
         start = (c == mid_start) || (late_start && (c >= done_exp - 1));
         @(negedge clk);
         gated = prev_hold;
         if (!gated) nh++;
         chk("busy", int'(busy), int'(c < done_exp));
         chk("done", int'(done), int'(c == done_exp));
         if (busy) bcnt++;
         if (gated) begin
            chk("held_rd_vld", int'(rd_vld), 0);
            chk("held_wr_vld", int'(wr_vld), 0);
            chk("held_rd_addr_a", int'(rd_addr_a), pa);
            chk("held_rd_addr_b", int'(rd_addr_b), pb);
            chk("held_tw_idx", int'(tw_idx), ptw);
            chk("held_wr_addr_a", int'(wr_addr_a), pwa);
            chk("held_wr_addr_b", int'(wr_addr_b), pwb);
            chk("held_stage", int'(stage), pst);
         end
         if (rd_vld) begin
            chk("rd_expected_avail", int'(exp_rd_q.size() > 0), 1);
            if (exp_rd_q.size() > 0) begin
               e = exp_rd_q.pop_front();
               chk("rd_addr_a", int'(rd_addr_a), e.a);
               chk("rd_addr_b", int'(rd_addr_b), e.b);
               chk("tw_idx", int'(tw_idx), e.tw);
               chk("rd_stage", int'(stage), e.s);
               if (timing) chk("rd_cycle", c, 10 * e.s + e.k + 1);
               if (e.k == 0 && e.s > 0) chk("raw_gap_ok", int'(nh - last_rd_nh > PIPE_LAT), 1);
               if (record) begin
                  obs_a[e.s][e.k]  = int'(rd_addr_a);
                  obs_b[e.s][e.k]  = int'(rd_addr_b);
                  obs_tw[e.s][e.k] = int'(tw_idx);
               end
            end
            w.a  = int'(rd_addr_a);
            w.b  = int'(rd_addr_b);
            w.nh = nh;
            sb_q.push_back(w);
            last_rd_nh = nh;
            rd_cnt++;
         end
         if (wr_vld) begin
            chk("wr_has_pending_rd", int'(sb_q.size() > 0), 1);
            if (sb_q.size() > 0) begin
               w = sb_q.pop_front();
               chk("wr_addr_a", int'(wr_addr_a), w.a);
               chk("wr_addr_b", int'(wr_addr_b), w.b);
               chk("wr_latency", nh - w.nh, PIPE_LAT);
            end
            wr_cnt++;
         end
         pa  = int'(rd_addr_a);
         pb  = int'(rd_addr_b);
         ptw = int'(tw_idx);
         pwa = int'(wr_addr_a);
         pwb = int'(wr_addr_b);
         pst = int'(stage);
         prev_hold = hold;
      end
      if (abort_cyc == 0) begin
         chk("rd_count", rd_cnt, NBF);
         chk("wr_count", wr_cnt, NBF);
         chk("busy_cycles", bcnt, done_exp - 1);
         chk("sb_drained", sb_q.size(), 0);
         chk("rd_list_drained", exp_rd_q.size(), 0);
      end
   endtask

   initial begin
      tbl[0] = '{s: 0, k: 0, a: 0, b: 1,  tw: 0};
      tbl[1] = '{s: 0, k: 3, a: 6, b: 7,  tw: 0};
      tbl[2] = '{s: 1, k: 1, a: 1, b: 3,  tw: 4};
      tbl[3] = '{s: 2, k: 5, a: 9, b: 13, tw: 2};
      tbl[4] = '{s: 3, k: 5, a: 5, b: 13, tw: 5};

      rstn  = 1'b0;
      start = 1'b0;
      hold  = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_outputs", all_outs(), 0);
      rstn = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("idle_busy", int'(busy), 0);
         chk("idle_done", int'(done), 0);
         chk("idle_rd_vld", int'(rd_vld), 0);
         chk("idle_wr_vld", int'(wr_vld), 0);
      end

      // plain run, stray start mid stage 2 and across the DONE/done cycles
      kick();
      run(-1, -1, -1, -1, 25, 41, 1'b1, 1'b1, 1'b1, 0);
      for (int i = 0; i < 5; i++) begin
         chk($sformatf("vec%0d_addr_a", i), obs_a[tbl[i].s][tbl[i].k], tbl[i].a);
         chk($sformatf("vec%0d_addr_b", i), obs_b[tbl[i].s][tbl[i].k], tbl[i].b);
         chk($sformatf("vec%0d_tw_idx", i), obs_tw[tbl[i].s][tbl[i].k], tbl[i].tw);
      end

      // start one cycle after the done pulse
      kick();
      run(-1, -1, -1, -1, 0, 41, 1'b1, 1'b0, 1'b0, 0);

      // 3-cycle stall at stage 1 k=4, 2-cycle stall in the stage 2 drain
      kick();
      run(14, 16, 31, 32, 0, 46, 1'b0, 1'b0, 1'b0, 0);

      // reset during stage 2 k=3
      kick();
      run(-1, -1, -1, -1, 0, 41, 1'b1, 1'b0, 1'b0, 24);
      chk("abort_pre_rd_addr_a", int'(rd_addr_a), 3);
      #1 rstn = 1'b0;
      #1 chk("abort_outputs", all_outs(), 0);
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      rstn = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         chk("post_abort_wr_vld", int'(wr_vld), 0);
         chk("post_abort_rd_vld", int'(rd_vld), 0);
         chk("post_abort_busy", int'(busy), 0);
      end

      kick();
      run(-1, -1, -1, -1, 0, 41, 1'b1, 1'b0, 1'b0, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
